mesm6_mem_arbiter: RTL and testbench

Shares one single-port external memory between the MESM-6 core's instruction bus (ibus) and data bus (dbus). It serialises concurrent fetch and read/write requests onto the memory port and latches read data per bus. It also holds each bus's `*_done` asserted until every request of the current microinstruction has completed, so the core's stall condition clears in a single cycle. It sits between `mesm6_core` and the memory/RAM controller.

---
 rtl/mesm6_arb_pkg.sv | 13 +
 rtl/mesm6_arb_port.sv | 43 ++++
 rtl/mesm6_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mesm6_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mesm6_arb_pkg.sv
// Shared types for the MESM-6 memory arbiter: FSM state encoding and bus index constants.
package mesm6_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM_I = 2'd1,
        MEM_D = 2'd2
    } arb_state_t;

    localparam logic ARB_I = 1'b0;
    localparam logic ARB_D = 1'b1;

endpackage

// File: rtl/mesm6_arb_port.sv
// One bus side of the arbiter: completion flag, latched read word and pending indication.
module mesm6_arb_port #(
    parameter int DW = 48
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic          i_ack,
    input  logic          i_is_read,
    input  logic          i_release,
    input  logic [DW-1:0] i_rdata,
    output logic          o_served,
    output logic          o_pending,
    output logic [DW-1:0] o_rdata
);

    logic          r_served;
    logic [DW-1:0] r_rdata;

    // A request dropped while its transfer is in flight must not be marked done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_served <= 1'b0;
        end else if (i_release) begin
            r_served <= 1'b0;
        end else if (i_ack && i_req) begin
            r_served <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (i_ack && i_req && i_is_read) begin
            r_rdata <= i_rdata;
        end
    end

    assign o_served  = r_served;
    assign o_pending = i_req & ~r_served;
    assign o_rdata   = r_rdata;

endmodule

// File: rtl/mesm6_mem_arbiter.sv
// Serialises MESM-6 ibus fetches and dbus reads/writes onto one memory port.
// Define MESM6_ARB_RR_EN for round-robin contention; default is fixed dbus priority.
module mesm6_mem_arbiter
    import mesm6_arb_pkg::*;
#(
    parameter int AW = 15,
    parameter int DW = 48
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ibus_fetch,
    input  logic [AW-1:0] ibus_addr,
    output logic [DW-1:0] ibus_input,
    output logic          ibus_done,
    input  logic          dbus_read,
    input  logic          dbus_write,
    input  logic [AW-1:0] dbus_addr,
    input  logic [DW-1:0] dbus_output,
    output logic [DW-1:0] dbus_input,
    output logic          dbus_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    arb_state_t    r_state;
    arb_state_t    w_state_nx;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          w_req_nx;
    logic          w_we_nx;
    logic [AW-1:0] w_addr_nx;
    logic [DW-1:0] w_wdata_nx;

    logic w_dbus_req;
    logic w_served_i;
    logic w_served_d;
    logic w_pend_i;
    logic w_pend_d;
    logic w_release;
    logic w_pick_d;
    logic w_grant;
    logic w_grant_d;

    assign w_dbus_req = dbus_read | dbus_write;

    // Release once every asserted request has completed, so the core unstalls in one cycle.
    assign w_release = (w_served_i | w_served_d)
                     & (~ibus_fetch | w_served_i)
                     & (~w_dbus_req | w_served_d);

    mesm6_arb_port #(.DW(DW)) u_port_i (
        .clk       (clk),
        .reset     (reset),
        .i_req     (ibus_fetch),
        .i_ack     (mem_ack && (r_state == MEM_I)),
        .i_is_read (1'b1),
        .i_release (w_release),
        .i_rdata   (mem_rdata),
        .o_served  (w_served_i),
        .o_pending (w_pend_i),
        .o_rdata   (ibus_input)
    );

    mesm6_arb_port #(.DW(DW)) u_port_d (
        .clk       (clk),
        .reset     (reset),
        .i_req     (w_dbus_req),
        .i_ack     (mem_ack && (r_state == MEM_D)),
        .i_is_read (~r_mem_we),
        .i_release (w_release),
        .i_rdata   (mem_rdata),
        .o_served  (w_served_d),
        .o_pending (w_pend_d),
        .o_rdata   (dbus_input)
    );

`ifdef MESM6_ARB_RR_EN
    logic r_token;

    // Token names the loser of the last two-way contention; it only moves on a real tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_token <= ARB_D;
        end else if ((r_state == IDLE) && w_pend_i && w_pend_d) begin
            r_token <= w_pick_d ? ARB_I : ARB_D;
        end
    end

    assign w_pick_d = (w_pend_i && w_pend_d) ? (r_token == ARB_D) : w_pend_d;
`else
    assign w_pick_d = w_pend_d;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_req_nx   = r_mem_req;
        w_we_nx    = r_mem_we;
        w_addr_nx  = r_mem_addr;
        w_wdata_nx = r_mem_wdata;
        w_grant    = 1'b0;
        w_grant_d  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pend_i || w_pend_d) begin
                    w_grant   = 1'b1;
                    w_grant_d = w_pick_d;
                end
            end
            MEM_I: begin
                if (mem_ack) begin
                    if (w_pend_d) begin
                        w_grant   = 1'b1;
                        w_grant_d = 1'b1;
                    end else begin
                        w_state_nx = IDLE;
                        w_req_nx   = 1'b0;
                    end
                end
            end
            MEM_D: begin
                if (mem_ack) begin
                    if (w_pend_i) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state_nx = IDLE;
                        w_req_nx   = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_req_nx   = 1'b0;
            end
        endcase
        if (w_grant) begin
            w_req_nx = 1'b1;
            if (w_grant_d) begin
                w_state_nx = MEM_D;
                w_addr_nx  = dbus_addr;
                w_we_nx    = dbus_write;
                w_wdata_nx = dbus_output;
            end else begin
                w_state_nx = MEM_I;
                w_addr_nx  = ibus_addr;
                w_we_nx    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_mem_req   <= w_req_nx;
            r_mem_we    <= w_we_nx;
            r_mem_addr  <= w_addr_nx;
            r_mem_wdata <= w_wdata_nx;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign ibus_done = w_served_i;
    assign dbus_done = w_served_d;

endmodule

// File: tb/tb_mesm6_mem_arbiter.sv
// Directed bench for mesm6_mem_arbiter with a wait-state memory responder.
// Honours MESM6_ARB_RR_EN for the expected grant order of the repeated dual request.
module tb_mesm6_mem_arbiter;

    localparam int AW = 15;
    localparam int DW = 48;

    logic          clk;
    logic          reset;
    logic          ibus_fetch;
    logic [AW-1:0] ibus_addr;
    logic [DW-1:0] ibus_input;
    logic          ibus_done;
    logic          dbus_read;
    logic          dbus_write;
    logic [AW-1:0] dbus_addr;
    logic [DW-1:0] dbus_output;
    logic [DW-1:0] dbus_input;
    logic          dbus_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    logic [DW-1:0] memory [0:255];
    logic          respEnable;
    int            waitStates;
    int            waitCnt;
    logic          autoAck;
    logic [DW-1:0] autoRdata;
    logic          manualAck;
    logic [DW-1:0] manualRdata;

    int checkCount;
    int failCount;

    mesm6_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ibus_fetch  (ibus_fetch),
        .ibus_addr   (ibus_addr),
        .ibus_input  (ibus_input),
        .ibus_done   (ibus_done),
        .dbus_read   (dbus_read),
        .dbus_write  (dbus_write),
        .dbus_addr   (dbus_addr),
        .dbus_output (dbus_output),
        .dbus_input  (dbus_input),
        .dbus_done   (dbus_done),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ack   = respEnable ? autoAck : manualAck;
    assign mem_rdata = respEnable ? autoRdata : manualRdata;

    // Memory answers on the falling edge after waitStates full cycles of mem_req.
    initial begin
        autoAck   = 1'b0;
        autoRdata = '0;
        waitCnt   = 0;
        forever begin
            @(negedge clk);
            autoAck = 1'b0;
            if (!mem_req) begin
                waitCnt = 0;
            end else if (waitCnt == waitStates) begin
                autoAck   = 1'b1;
                autoRdata = memory[mem_addr[7:0]];
                waitCnt   = 0;
            end else begin
                waitCnt = waitCnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fetch, input logic rd, input logic wr,
                                 input logic [AW-1:0] iaddr, input logic [AW-1:0] daddr,
                                 input logic [DW-1:0] wdata);
        ibus_fetch  = fetch;
        dbus_read   = rd;
        dbus_write  = wr;
        ibus_addr   = iaddr;
        dbus_addr   = daddr;
        dbus_output = wdata;
    endtask

    // Fetch + read together with 3 wait states; dFirst selects which bus should win.
    task automatic runDual(input logic [AW-1:0] iaddr, input logic [AW-1:0] daddr,
                           input logic dFirst);
        logic [AW-1:0] firstAddr;
        logic [AW-1:0] secondAddr;
        firstAddr  = dFirst ? daddr : iaddr;
        secondAddr = dFirst ? iaddr : daddr;
        waitStates = 3;
        applyStimulus(1'b1, 1'b1, 1'b0, iaddr, daddr, '0);
        tick();
        checkOutput("dual first addr", DW'(mem_addr), DW'(firstAddr));
        checkOutput("dual first req", DW'(mem_req), DW'(1'b1));
        tick(); tick(); tick();
        checkOutput("dual wait req held", DW'(mem_req), DW'(1'b1));
        checkOutput("dual wait addr held", DW'(mem_addr), DW'(firstAddr));
        checkOutput("dual wait no done", DW'({ibus_done, dbus_done}), DW'(2'b00));
        tick();
        checkOutput("dual first done", DW'({ibus_done, dbus_done}), DW'(dFirst ? 2'b01 : 2'b10));
        checkOutput("dual second addr", DW'(mem_addr), DW'(secondAddr));
        checkOutput("dual req kept", DW'(mem_req), DW'(1'b1));
        tick(); tick(); tick();
        checkOutput("dual first done held", DW'({ibus_done, dbus_done}), DW'(dFirst ? 2'b01 : 2'b10));
        tick();
        checkOutput("dual both done", DW'({ibus_done, dbus_done}), DW'(2'b11));
        checkOutput("dual req dropped", DW'(mem_req), DW'(1'b0));
        checkOutput("dual ibus data", ibus_input, memory[iaddr[7:0]]);
        checkOutput("dual dbus data", dbus_input, memory[daddr[7:0]]);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        checkOutput("dual release", DW'({ibus_done, dbus_done}), DW'(2'b00));
        checkOutput("dual ibus data kept", ibus_input, memory[iaddr[7:0]]);
    endtask

    initial begin
        logic secondDFirst;
        checkCount  = 0;
        failCount   = 0;
        respEnable  = 1'b1;
        waitStates  = 0;
        manualAck   = 1'b0;
        manualRdata = '0;
        for (int i = 0; i < 256; i++) memory[i] = DW'(i) * 48'h0001_0001_0001;
        memory[8'o100] = 48'o1234;
        memory[10]     = 48'hAAAA_0000_1111;
        memory[20]     = 48'hBBBB_2222_3333;
        memory[11]     = 48'hCCCC_4444_5555;
        memory[21]     = 48'hDDDD_6666_7777;
        memory[30]     = 48'h0E0E_0E0E_0E0E;
        memory[31]     = 48'hF1F1_F1F1_F1F1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        reset = 1'b0;
        tick(); tick();
        checkOutput("reset mem_req", DW'(mem_req), DW'(1'b0));
        checkOutput("reset mem_we", DW'(mem_we), DW'(1'b0));
        checkOutput("reset done", DW'({ibus_done, dbus_done}), DW'(2'b00));
        checkOutput("reset mem_addr", DW'(mem_addr), '0);
        checkOutput("reset mem_wdata", mem_wdata, '0);
        checkOutput("reset ibus_input", ibus_input, '0);
        checkOutput("reset dbus_input", dbus_input, '0);
        reset = 1'b1;
        tick();

        $display("[TB] single fetch, zero wait");
        applyStimulus(1'b1, 1'b0, 1'b0, 15'o100, '0, '0);
        tick();
        checkOutput("fetch req", DW'(mem_req), DW'(1'b1));
        checkOutput("fetch addr", DW'(mem_addr), DW'(15'o100));
        checkOutput("fetch we", DW'(mem_we), DW'(1'b0));
        checkOutput("fetch early done", DW'(ibus_done), DW'(1'b0));
        tick();
        checkOutput("fetch req one cycle", DW'(mem_req), DW'(1'b0));
        checkOutput("fetch done", DW'(ibus_done), DW'(1'b1));
        checkOutput("fetch data", ibus_input, 48'o1234);
        checkOutput("fetch dbus idle", DW'(dbus_done), DW'(1'b0));
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        checkOutput("fetch release", DW'(ibus_done), DW'(1'b0));

        $display("[TB] write, zero wait");
        applyStimulus(1'b0, 1'b0, 1'b1, '0, 15'o77, 48'h1234_5678_9ABC);
        tick();
        checkOutput("write req", DW'(mem_req), DW'(1'b1));
        checkOutput("write we", DW'(mem_we), DW'(1'b1));
        checkOutput("write addr", DW'(mem_addr), DW'(15'o77));
        checkOutput("write data", mem_wdata, 48'h1234_5678_9ABC);
        tick();
        checkOutput("write done", DW'({ibus_done, dbus_done}), DW'(2'b01));
        checkOutput("write req drop", DW'(mem_req), DW'(1'b0));
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        checkOutput("write release", DW'(dbus_done), DW'(1'b0));

        $display("[TB] dual fetch+read, 3 wait states");
        runDual(15'd10, 15'd20, 1'b1);
`ifdef MESM6_ARB_RR_EN
        secondDFirst = 1'b0;
`else
        secondDFirst = 1'b1;
`endif
        runDual(15'd11, 15'd21, secondDFirst);

        $display("[TB] back-to-back reads");
        waitStates = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 15'd30, '0);
        tick();
        tick();
        checkOutput("b2b first done", DW'(dbus_done), DW'(1'b1));
        checkOutput("b2b first data", dbus_input, 48'h0E0E_0E0E_0E0E);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        checkOutput("b2b released", DW'(dbus_done), DW'(1'b0));
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 15'd31, '0);
        tick();
        checkOutput("b2b no dead cycle", DW'(mem_req), DW'(1'b1));
        checkOutput("b2b second addr", DW'(mem_addr), DW'(15'd31));
        tick();
        checkOutput("b2b second data", dbus_input, 48'hF1F1_F1F1_F1F1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();

        $display("[TB] reset during transfer");
        waitStates = 3;
        applyStimulus(1'b1, 1'b0, 1'b0, 15'd5, '0, '0);
        tick();
        checkOutput("pre-reset req", DW'(mem_req), DW'(1'b1));
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset req", DW'(mem_req), DW'(1'b0));
        checkOutput("async reset addr", DW'(mem_addr), '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        reset       = 1'b1;
        respEnable  = 1'b0;
        manualRdata = 48'hDEAD_BEEF_CAFE;
        manualAck   = 1'b1;
        tick();
        manualAck = 1'b0;
        tick();
        checkOutput("late ack req", DW'(mem_req), DW'(1'b0));
        checkOutput("late ack done", DW'({ibus_done, dbus_done}), DW'(2'b00));
        checkOutput("late ack ibus data", ibus_input, '0);
        checkOutput("late ack dbus data", dbus_input, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
